// File: rtl/audio_sample_player.sv
// Purpose : mono PCM clip player; ROM samples out as I2S to a codec that masters bclk/lrclk.
// Latency : 3-4 Clk from a codec bclk fall to the sdata update (2-flop sync + edge flop + output reg).
// Backpressure: none; all progress is paced by codec clock edges, which freeze everything when absent.
//
// Ports:
//   Clk        system clock; all logic is synchronous to it
//   Reset_n    asynchronous active-low reset
//   play       level request, sampled only at left-frame boundaries
//   bclk       codec bit clock (async to Clk)
//   lrclk      codec word clock (async to Clk), low = left channel
//   rom_q      ROM read data, valid 1 Clk after rom_addr changes
//   rom_addr   ROM address of the next sample to consume
//   sdata      I2S serial data to the codec
//   busy       high while a clip is playing
//   clip_done  one-Clk pulse when the last sample of a clip is consumed
module audio_sample_player #(
  parameter int SAMPLE_LEN = 15800,
  parameter int ADDR_W     = 14,
  parameter int SAMPLE_W   = 8
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                play,
  input  logic                bclk,
  input  logic                lrclk,
  input  logic [SAMPLE_W-1:0] rom_q,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                sdata,
  output logic                busy,
  output logic                clip_done
);

  localparam int                  SLOT_W    = 32;
  localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(SAMPLE_LEN - 1);
  // Unsigned mid-scale: silence in unsigned PCM, and the XOR mask that turns
  // unsigned into two's complement.
  localparam logic [SAMPLE_W-1:0] MID       = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {
    IDLE,
    PLAY
  } state_e;

  // --------------------------------------------------------------------------
  // Codec clock synchronizers: [0],[1] resolve metastability, [2] is the
  // previous synchronized value used for edge detection.
  // --------------------------------------------------------------------------
  logic [2:0] bclk_sync_q;
  logic [2:0] lrclk_sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_sync_q  <= 3'b000;
      lrclk_sync_q <= 3'b000;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[1:0], bclk};
      lrclk_sync_q <= {lrclk_sync_q[1:0], lrclk};
    end
  end

  logic bfall;
  logic lredge;
  logic lfall;

  assign bfall  = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lredge = lrclk_sync_q[2] ^ lrclk_sync_q[1];
  assign lfall  = lrclk_sync_q[2] & ~lrclk_sync_q[1];

  // --------------------------------------------------------------------------
  // Playback FSM. Next-state values are formed combinationally so the slot
  // loader below can see the sample chosen at the same left-frame boundary.
  // --------------------------------------------------------------------------
  state_e                state_q,      state_d;
  logic [ADDR_W-1:0]     rom_addr_q,   rom_addr_d;
  logic [SAMPLE_W-1:0]   cur_sample_q, cur_sample_d;
  logic                  busy_q,       busy_d;
  logic                  clip_done_q,  clip_done_d;

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    cur_sample_d = cur_sample_q;
    clip_done_d  = 1'b0;

    if (lfall) begin
      unique case (state_q)
        IDLE: begin
          // Starting a clip leaves the sample alone, so the first frame of a
          // clip is silence while ROM word 0 is already on rom_q.
          if (play) begin
            state_d = PLAY;
          end else begin
            cur_sample_d = MID;
          end
        end
        PLAY: begin
          cur_sample_d = rom_q;
          if (rom_addr_q == ADDR_LAST) begin
            clip_done_d = 1'b1;
            rom_addr_d  = '0;
            // play is only consulted here, so a mid-clip release still
            // lets the clip finish; holding it retriggers gaplessly.
            if (!play) begin
              state_d = IDLE;
            end
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      cur_sample_q <= MID;
      busy_q       <= 1'b0;
      clip_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      cur_sample_q <= cur_sample_d;
      busy_q       <= busy_d;
      clip_done_q  <= clip_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // I2S serializer. The slot is loaded on the bclk fall that carries the
  // lrclk change and sdata is held for that bit, which places the MSB one
  // bclk after the word-clock edge. Both channels get the same sample.
  // --------------------------------------------------------------------------
  logic [SLOT_W-1:0] shift_q, shift_d;
  logic              sdata_q, sdata_d;
  logic [SLOT_W-1:0] slot_word;

  assign slot_word = {cur_sample_d ^ MID, {(SLOT_W-SAMPLE_W){1'b0}}};

  always_comb begin
    shift_d = shift_q;
    sdata_d = sdata_q;
    if (bfall) begin
      if (lredge) begin
        shift_d = slot_word;
      end else begin
        sdata_d = shift_q[SLOT_W-1];
        shift_d = {shift_q[SLOT_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_q <= '0;
      sdata_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      sdata_q <= sdata_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign sdata     = sdata_q;
  assign busy      = busy_q;
  assign clip_done = clip_done_q;

endmodule

// File: doc/audio_sample_player.md
AUDIO_SAMPLE_PLAYER -- requirements
Module: audio_sample_player

Interface
REQ-001 SHALL have parameter SAMPLE_LEN, default 15800, meaning number of ROM samples in one clip.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning ROM address width.
REQ-003 SHALL have parameter SAMPLE_W, default 8, meaning ROM word width, unsigned PCM.
REQ-004 Clk  in  1  system clock (50 MHz); all logic is synchronous to Clk.
REQ-005 Reset_n  in  1  reset, asynchronous and active-low.
REQ-006 play  in  1  level request from game logic; sampled only at left-frame boundaries.
REQ-007 bclk  in  1  codec I2S bit clock, asynchronous to Clk.
REQ-008 lrclk  in  1  codec I2S word clock, asynchronous to Clk; low = left.
REQ-009 rom_q  in  SAMPLE_W  ROM read data, valid 1 Clk after rom_addr changes.
REQ-010 rom_addr  out  ADDR_W  ROM address of next sample.
REQ-011 sdata  out  1  I2S serial data to codec.
REQ-012 busy  out  1  high while a clip is playing.
REQ-013 clip_done  out  1  one-Clk pulse when the last sample of a clip is consumed.

Function
REQ-014 SHALL pass bclk and lrclk each through a 2-flop synchronizer, then a third flop for edge detection.
REQ-015 SHALL flag bfall for 1 Clk on each synchronized bclk 1->0 transition; SHALL flag lredge on any synchronized lrclk transition; SHALL flag lfall on synchronized lrclk 1->0 (left-frame boundary).
REQ-016 SHALL hold a 32-bit shift register; on bfall with lredge in the same cycle, SHALL load slot word and leave sdata unchanged.
REQ-017 Slot word SHALL be {cur_sample ^ 8'h80, 24'h000000}: signed 8-bit PCM left-justified in a 32-bit slot.
REQ-018 On bfall without lredge, SHALL drive sdata <= shift[31] and shift <= shift << 1, zero fill; so MSB appears one bclk after the lrclk change (I2S standard).
REQ-019 Both channels SHALL carry the same cur_sample (mono).
REQ-020 FSM states: IDLE, PLAY.
REQ-021 IDLE: cur_sample = 8'h80 (silence); rom_addr = 0; busy = 0.
REQ-022 IDLE -> PLAY on lfall with play = 1; rom_addr stays 0 and cur_sample is unchanged at this boundary.
REQ-023 PLAY, on each lfall: cur_sample <= rom_q and rom_addr <= rom_addr + 1; busy = 1.
REQ-024 PLAY, on the lfall that consumes address SAMPLE_LEN-1: set clip_done for that cycle and rom_addr <= 0.
REQ-025 At that same lfall, with play = 1, SHALL stay in PLAY (retrigger, gapless); with play = 0, SHALL go to IDLE.
REQ-026 Deasserting play mid-clip SHALL NOT stop the clip; the clip always completes.
REQ-027 rom_addr SHALL never exceed SAMPLE_LEN-1.
REQ-028 Absence of bclk/lrclk SHALL freeze all state; no timeout.
REQ-029 Slot load (REQ-016) SHALL sample cur_sample after any same-cycle lfall update, so a new sample is used in the frame that begins at that boundary.

Reset
REQ-030 On Reset_n low, SHALL asynchronously clear: FSM to IDLE, rom_addr 0, cur_sample 8'h80, shift 0, sdata 0, busy 0, clip_done 0, synchronizer flops 0.
REQ-031 Reset mid-clip SHALL abort playback; the first frame after release SHALL be silence unless play is high at the next lfall.
REQ-032 After release, an lrclk/bclk edge whose synchronized transition completes in the first 3 Clk SHALL NOT be required to be detected.

Verification
REQ-033 Idle, play = 0, bclk = 3.072 MHz, lrclk = 48 kHz: sdata slot = 0x00000000 every frame; busy = 0.
REQ-034 play pulsed high across one lfall, ROM word = addr[7:0]: busy rises at that lfall; next left slot MSBs = 0x80 (sample 0 ^ 0x80); following slot = 0x81; data is MSB-first, one bclk after lrclk edge.
REQ-035 SAMPLE_LEN overridden to 4, play held high: rom_addr sequence 0,1,2,3,0,1..., clip_done pulses every 4 frames, busy never drops.
REQ-036 SAMPLE_LEN = 4, play dropped after 1 frame: exactly 4 samples output, single clip_done, then IDLE with busy = 0 and slots 0x00000000.
REQ-037 Reset_n asserted at sample 2 of a clip: all outputs 0 / rom_addr 0 immediately (no Clk edge needed); first frame after release is silence.
REQ-038 bclk/lrclk phase swept against Clk (random 0-19 ns offset): no missed or doubled bits over 1000 frames; decoded samples match ROM.
